// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle controller:
// opcodes, FSM states, ALU/immediate/mux select codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXER, S_EXEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_LUI
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function fields onto the ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // opb5 separates R-type from I-ALU so addi never becomes sub
                    3'b000:  alucontrol = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alucontrol = ALU_AND;
                    3'b110:  alucontrol = ALU_OR;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLTU;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences
// fetch/decode/execute/memory/writeback and drives datapath controls.
module controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       Zero,
    input  logic       ALUResSign,
    input  logic [6:0] op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc
);

    state_t  state, next;
    alu_op_t aluop;
    logic    pc_we, mem_we, ir_we, reg_we, taken;
    logic    unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next;
    end

    always_comb begin
        case (op)
            OP_I, OP_LW, OP_JALR: ImmSrc = IMM_I;
            OP_SW:                ImmSrc = IMM_S;
            OP_BR:                ImmSrc = IMM_B;
            OP_JAL:               ImmSrc = IMM_J;
            OP_LUI:               ImmSrc = IMM_U;
            default:              ImmSrc = IMM_I;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = ALUResSign;
            3'b101:  taken = !ALUResSign;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next      = S_FETCH;
        pc_we     = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        aluop     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_R:         next = S_EXER;
                    OP_I:         next = S_EXEI;
                    OP_BR:        next = S_BRANCH;
                    OP_JAL:       next = S_JAL;
                    OP_JALR:      next = S_JALR;
                    OP_LUI:       next = S_LUI;
                    default:      next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                next   = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_MDR;
                reg_we    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
            end
            S_EXER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                aluop   = ALUOP_FUNCT;
                next    = S_ALUWB;
            end
            S_EXEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                next    = S_ALUWB;
            end
            S_ALUWB: reg_we = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                aluop   = ALUOP_SUB;
                pc_we   = taken;
            end
            // ALUOut holds the target from DECODE while the ALU forms OldPC+4
            S_JAL, S_JALRPC: begin
                pc_we   = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                next    = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                next    = S_JALRPC;
            end
            S_LUI: begin
                ResultSrc = RES_IMM;
                reg_we    = 1'b1;
            end
            default: next = S_FETCH;
        endcase
    end

    assign PCWrite  = pc_we  && !rst;
    assign MemWrite = mem_we && !rst;
    assign IRWrite  = ir_we  && !rst;
    assign RegWrite = reg_we && !rst;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7[5]),
        .opb5       (op[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_controller.sv
// Directed test of the multi-cycle controller: walks each instruction class
// through its states and checks the control outputs cycle by cycle.
module tb_controller;

    logic       clk, rst, Zero, ALUResSign;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [2:0] ImmSrc, ALUControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    int checks = 0;
    int errors = 0;

    controller dut (
        .clk        (clk),
        .rst        (rst),
        .Zero       (Zero),
        .ALUResSign (ALUResSign),
        .op         (op),
        .funct7     (funct7),
        .funct3     (funct3),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        rst = 1'b1; Zero = 1'b0; ALUResSign = 1'b0;
        instr(7'b0110011, 3'b000, 7'b0000000);

        // reset held two cycles
        step();
        step();
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_memwrite", MemWrite, 0);
        rst = 1'b0;
        #1;
        chk("fetch_pcwrite", PCWrite, 1);
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_srcb", ALUSrcB, 2'b10);
        chk("fetch_ressrc", ResultSrc, 2'b10);
        chk("fetch_adrsrc", AdrSrc, 0);

        // R-type sub
        instr(7'b0110011, 3'b000, 7'b0100000);
        step();
        chk("dec_srca", ALUSrcA, 2'b01);
        chk("dec_srcb", ALUSrcB, 2'b01);
        chk("dec_aluctl", ALUControl, 3'b000);
        step();
        chk("exer_sub", ALUControl, 3'b001);
        chk("exer_srca", ALUSrcA, 2'b10);
        chk("exer_srcb", ALUSrcB, 2'b00);
        chk("exer_regwrite", RegWrite, 0);
        step();
        chk("aluwb_regwrite", RegWrite, 1);
        chk("aluwb_ressrc", ResultSrc, 2'b00);
        step();
        chk("r_back_fetch", IRWrite, 1);

        // R-type slt and sll (funct3 001 falls back to add)
        instr(7'b0110011, 3'b010, 7'b0000000);
        step(); step();
        chk("exer_slt", ALUControl, 3'b101);
        step(); step();
        instr(7'b0110011, 3'b001, 7'b0000000);
        step(); step();
        chk("exer_sll_add", ALUControl, 3'b000);
        step(); step();

        // I-ALU with funct7[5]=1 and funct3 000 stays add
        instr(7'b0010011, 3'b000, 7'b0100000);
        step(); step();
        chk("exei_add", ALUControl, 3'b000);
        chk("exei_srcb", ALUSrcB, 2'b01);
        step(); step();
        instr(7'b0010011, 3'b111, 7'b0000000);
        step(); step();
        chk("exei_and", ALUControl, 3'b010);
        step(); step();

        // LW
        instr(7'b0000011, 3'b010, 7'b0000000);
        step();
        step();
        chk("memadr_srcb", ALUSrcB, 2'b01);
        chk("memadr_srca", ALUSrcA, 2'b10);
        chk("lw_immsrc", ImmSrc, 3'b000);
        step();
        chk("memrd_adrsrc", AdrSrc, 1);
        chk("memrd_memwrite", MemWrite, 0);
        step();
        chk("memwb_ressrc", ResultSrc, 2'b01);
        chk("memwb_regwrite", RegWrite, 1);
        step();
        chk("lw_back_fetch", IRWrite, 1);

        // SW
        instr(7'b0100011, 3'b010, 7'b0000000);
        step(); step(); step();
        chk("memwr_memwrite", MemWrite, 1);
        chk("memwr_adrsrc", AdrSrc, 1);
        chk("sw_immsrc", ImmSrc, 3'b001);
        chk("memwr_regwrite", RegWrite, 0);
        step();
        chk("sw_back_fetch", IRWrite, 1);

        // beq taken
        instr(7'b1100011, 3'b000, 7'b0000000);
        Zero = 1'b1;
        step();
        chk("br_immsrc", ImmSrc, 3'b010);
        step();
        chk("beq_taken", PCWrite, 1);
        chk("br_aluctl", ALUControl, 3'b001);
        chk("br_srca", ALUSrcA, 2'b10);
        step();
        chk("br_back_fetch", IRWrite, 1);

        // beq not taken
        Zero = 1'b0;
        step(); step();
        chk("beq_not_taken", PCWrite, 0);
        step();

        // bne with Zero=0 taken
        instr(7'b1100011, 3'b001, 7'b0000000);
        step(); step();
        chk("bne_taken", PCWrite, 1);
        step();

        // blt sign=1 taken, bge sign=1 not taken
        instr(7'b1100011, 3'b100, 7'b0000000);
        ALUResSign = 1'b1;
        step(); step();
        chk("blt_taken", PCWrite, 1);
        step();
        instr(7'b1100011, 3'b101, 7'b0000000);
        step(); step();
        chk("bge_not_taken", PCWrite, 0);
        step();

        // unsupported funct3 never taken
        instr(7'b1100011, 3'b010, 7'b0000000);
        Zero = 1'b1;
        step(); step();
        chk("br_f3_010", PCWrite, 0);
        step();
        Zero = 1'b0; ALUResSign = 1'b0;

        // JAL
        instr(7'b1101111, 3'b000, 7'b0000000);
        step();
        chk("jal_immsrc", ImmSrc, 3'b011);
        step();
        chk("jal_pcwrite", PCWrite, 1);
        chk("jal_ressrc", ResultSrc, 2'b00);
        chk("jal_srca", ALUSrcA, 2'b01);
        chk("jal_srcb", ALUSrcB, 2'b10);
        chk("jal_regwrite", RegWrite, 0);
        step();
        chk("jal_wb", RegWrite, 1);
        step();
        chk("jal_back_fetch", IRWrite, 1);

        // JALR
        instr(7'b1100111, 3'b000, 7'b0000000);
        step(); step();
        chk("jalr_pcwrite", PCWrite, 0);
        chk("jalr_srca", ALUSrcA, 2'b10);
        chk("jalr_srcb", ALUSrcB, 2'b01);
        step();
        chk("jalrpc_pcwrite", PCWrite, 1);
        chk("jalrpc_srca", ALUSrcA, 2'b01);
        chk("jalrpc_srcb", ALUSrcB, 2'b10);
        step();
        chk("jalr_wb", RegWrite, 1);
        step();
        chk("jalr_back_fetch", IRWrite, 1);

        // LUI
        instr(7'b0110111, 3'b000, 7'b0000000);
        step(); step();
        chk("lui_immsrc", ImmSrc, 3'b100);
        chk("lui_ressrc", ResultSrc, 2'b11);
        chk("lui_regwrite", RegWrite, 1);
        step();
        chk("lui_back_fetch", IRWrite, 1);

        // illegal opcode
        instr(7'b1111111, 3'b000, 7'b0000000);
        step();
        chk("ill_regwrite", RegWrite, 0);
        chk("ill_memwrite", MemWrite, 0);
        chk("ill_immsrc", ImmSrc, 3'b000);
        step();
        chk("ill_back_fetch", IRWrite, 1);

        // reset mid-instruction aborts it
        instr(7'b0110011, 3'b000, 7'b0000000);
        step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_pcwrite", PCWrite, 0);
        chk("midrst_irwrite", IRWrite, 0);
        step();
        chk("midrst_regwrite", RegWrite, 0);
        rst = 1'b0;
        #1;
        chk("midrst_fetch", IRWrite, 1);
        chk("midrst_fetch_pc", PCWrite, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
